fb_write_arbiter: RTL

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fbw_pkg.sv | 21 ++
 rtl/fb_write_arbiter_rr_pick2.sv | 28 ++
 rtl/fb_write_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fbw_pkg.sv
// Shared definitions for the framebuffer write arbiter: channel map, group
// masks, FSM state encoding and coordinate/pixel widths.
package fbw_pkg;

  localparam int NUM_CH  = 4;
  localparam int COORD_W = 10;
  localparam int PIX_W   = 8;

  // First channel of each group; the low index bit selects within the group.
  localparam logic [1:0] CH_DRAW_BASE  = 2'd0;
  localparam logic [1:0] CH_ERASE_BASE = 2'd2;

  localparam logic [NUM_CH-1:0] DRAW_MASK  = 4'b0011;
  localparam logic [NUM_CH-1:0] ERASE_MASK = 4'b1100;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } fbw_state_e;

endpackage

// File: rtl/fb_write_arbiter_rr_pick2.sv
// Two-way round-robin pick. The pointer names the preferred channel; after a
// completed burst it moves to the channel following the one that finished.
module rr_pick2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       adv_owner,
  output logic       pick
);

  logic ptr;

  // Prefer the pointed-at channel, fall back to the other one.
  always_comb begin
    pick = req[ptr] ? ptr : ~ptr;
  end

  // Pointer update on burst completion within this group.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (adv) begin
      ptr <= ~adv_owner;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Four-channel framebuffer write arbiter. Erase channels (2,3) beat draw
// channels (0,1); round-robin within each group; a burst locks the port to
// its owner until its last beat or until the owner stays idle TIMEOUT cycles.
// Optional feature: define FBW_BOUNDS_CHECK_EN to suppress writes whose
// coordinates fall outside X_MAX x Y_MAX and count them in drop_count.
module fb_write_arbiter
  import fbw_pkg::*;
#(
  parameter int X_MAX   = 640,
  parameter int Y_MAX   = 480,
  parameter int TIMEOUT = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req_valid,
  input  logic [NUM_CH-1:0]         req_last,
  input  logic [NUM_CH*COORD_W-1:0] req_x,
  input  logic [NUM_CH*COORD_W-1:0] req_y,
  input  logic [NUM_CH*PIX_W-1:0]   req_data,
  output logic [NUM_CH-1:0]         req_ready,
  output logic                      wr_en,
  output logic [COORD_W-1:0]        wr_x,
  output logic [COORD_W-1:0]        wr_y,
  output logic [PIX_W-1:0]          wr_data,
  output logic [1:0]                grant_id,
  output logic                      busy,
  output logic [15:0]               drop_count
);

  localparam logic [COORD_W:0] X_LIM   = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0] Y_LIM   = (COORD_W+1)'(Y_MAX);
  localparam logic [15:0]      TO_LAST = 16'(TIMEOUT - 1);

  fbw_state_e         state;
  logic [1:0]         owner;
  logic [15:0]        idle_cnt;
  logic               draw_pick;
  logic               erase_pick;
  logic               erase_any;
  logic [1:0]         winner;
  logic [1:0]         xfer_ch;
  logic               xfer;
  logic               xfer_last;
  logic [COORD_W-1:0] sel_x;
  logic [COORD_W-1:0] sel_y;
  logic [PIX_W-1:0]   sel_data;
  logic               oob;

  rr_pick2 u_draw_rr (
    .clock     (clock),
    .reset     (reset),
    .req       (req_valid[1:0]),
    .adv       (xfer && xfer_last && !xfer_ch[1]),
    .adv_owner (xfer_ch[0]),
    .pick      (draw_pick)
  );

  rr_pick2 u_erase_rr (
    .clock     (clock),
    .reset     (reset),
    .req       (req_valid[3:2]),
    .adv       (xfer && xfer_last && xfer_ch[1]),
    .adv_owner (xfer_ch[0]),
    .pick      (erase_pick)
  );

  // Winner selection, ready generation and mux of the transferring beat.
  always_comb begin
    erase_any = |(req_valid & ERASE_MASK);
    winner    = erase_any ? (CH_ERASE_BASE | {1'b0, erase_pick})
                          : (CH_DRAW_BASE  | {1'b0, draw_pick});
    xfer_ch   = (state == ST_LOCKED) ? owner : winner;
    req_ready = '0;
    if (!reset) begin
      if (state == ST_LOCKED) begin
        req_ready[owner] = 1'b1;
      end else if ((|(req_valid & DRAW_MASK)) || erase_any) begin
        req_ready[winner] = 1'b1;
      end
    end
    xfer      = |(req_valid & req_ready);
    xfer_last = req_last[xfer_ch];
    sel_x     = req_x[xfer_ch*COORD_W +: COORD_W];
    sel_y     = req_y[xfer_ch*COORD_W +: COORD_W];
    sel_data  = req_data[xfer_ch*PIX_W +: PIX_W];
    oob       = ({1'b0, sel_x} >= X_LIM) || ({1'b0, sel_y} >= Y_LIM);
  end

  // Burst lock FSM with owner-idle timeout; busy mirrors the LOCKED state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      owner    <= 2'd0;
      idle_cnt <= 16'd0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          idle_cnt <= 16'd0;
          if (xfer && !xfer_last) begin
            state <= ST_LOCKED;
            owner <= winner;
            busy  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (xfer) begin
            idle_cnt <= 16'd0;
            if (xfer_last) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (idle_cnt == TO_LAST) begin
            idle_cnt <= 16'd0;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
      endcase
    end
  end

`ifdef FBW_BOUNDS_CHECK_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Write stage (_p1): out-of-bounds beats are consumed but not written.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_data    <= '0;
      grant_id   <= 2'd0;
      drop_count <= 16'd0;
    end else begin
      wr_en <= xfer && !oob;
      if (xfer) begin
        wr_x     <= sel_x;
        wr_y     <= sel_y;
        wr_data  <= sel_data;
        grant_id <= xfer_ch;
      end
      if (xfer && oob) begin
        drop_count <= sat_inc(drop_count);
      end
    end
  end
`else
  logic unused_oob;
  assign unused_oob = oob;
  assign drop_count = 16'd0;

  // Write stage (_p1): every transferred beat is written.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_data  <= '0;
      grant_id <= 2'd0;
    end else begin
      wr_en <= xfer;
      if (xfer) begin
        wr_x     <= sel_x;
        wr_y     <= sel_y;
        wr_data  <= sel_data;
        grant_id <= xfer_ch;
      end
    end
  end
`endif

endmodule
